// File: rtl/cache_bus_ctrl.sv
// Single-block snooping cache controller: MSI line state, bus arbitration and
// messages, write-back of dirty data, fill from memory and IDLE-time snooping.
module cache_bus_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_tag,
    input  logic [9:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [9:0]  cpu_rdata,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [15:0] bus,
    input  logic [15:0] mem_block,
    output logic        wb,
    output logic [15:0] wb_block,
    input  logic [15:0] snoop,
    output logic [15:0] block
);
    typedef enum logic [2:0] {IDLE, CHECK, WB, ARB, MSG, WAIT, FILL, DONE} state_t;

    localparam logic [1:0]  OP_RD    = 2'b00;
    localparam logic [1:0]  OP_WR    = 2'b01;
    localparam logic [1:0]  OP_INV   = 2'b10;
    localparam logic [1:0]  OP_IDLE  = 2'b11;
    localparam logic [1:0]  ST_I     = 2'b00;
    localparam logic [1:0]  ST_S     = 2'b01;
    localparam logic [1:0]  ST_M     = 2'b10;
    localparam logic [15:0] BUS_IDLE = 16'hC000;
    localparam logic [2:0]  LAT_LAST = 3'(MEM_LAT - 1);

    state_t     state;
    logic       req_we;
    logic [3:0] req_tag;
    logic [9:0] req_wdata;
    logic [1:0] req_op;
    logic [2:0] lat_cnt;

    logic [3:0] blk_tag;
    logic [1:0] blk_st;
    logic [9:0] blk_data;
    logic       cpu_hit;
    logic [1:0] snoop_op;
    logic       snoop_hit;
    logic       unused_bits;

    assign blk_tag   = block[15:12];
    assign blk_st    = block[11:10];
    assign blk_data  = block[9:0];
    assign cpu_hit   = (req_tag == blk_tag) && (blk_st != ST_I);
    assign snoop_op  = snoop[15:14];
    assign snoop_hit = (snoop[13:10] == blk_tag) && (blk_st != ST_I) && (snoop_op != OP_IDLE);
    assign unused_bits = ^{mem_block[11:10], snoop[9:0]};

    // NOTE: the cached block is architectural state, so it is reset like any
    // other register; an abandoned access must leave an invalid line behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            block     <= '0;
            bus       <= BUS_IDLE;
            wb_block  <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            bus_req   <= 1'b0;
            wb        <= 1'b0;
            lat_cnt   <= '0;
            req_we    <= 1'b0;
            req_tag   <= '0;
            req_wdata <= '0;
            req_op    <= OP_RD;
        end else begin
            // NOTE: non-blocking assignments only, so every decision below sees
            // the pre-edge block and state even after an earlier branch wrote them.
            cpu_ready <= 1'b0;
            wb        <= 1'b0;
            bus       <= BUS_IDLE;
            case (state)
                IDLE: begin
                    if (snoop_hit) begin
                        if (blk_st == ST_M) begin
                            wb       <= 1'b1;
                            wb_block <= block;
                        end
                        block[11:10] <= (snoop_op == OP_RD) ? ST_S : ST_I;
                    end
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_tag   <= cpu_tag;
                        req_wdata <= cpu_wdata;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    req_op <= req_we ? OP_WR : OP_RD;
                    if (cpu_hit && !req_we) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= blk_data;
                        state     <= DONE;
                    end else if (cpu_hit && blk_st == ST_M) begin
                        block[9:0] <= req_wdata;
                        cpu_ready  <= 1'b1;
                        cpu_rdata  <= req_wdata;
                        state      <= DONE;
                    end else if (cpu_hit) begin
                        // Shared write hit: other copies must be invalidated first.
                        req_op  <= OP_INV;
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end else if (blk_st == ST_M) begin
                        wb       <= 1'b1;
                        wb_block <= block;
                        state    <= WB;
                    end else begin
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end
                end
                WB: begin
                    bus_req <= 1'b1;
                    state   <= ARB;
                end
                ARB: begin
                    if (bus_grant) begin
                        bus   <= {req_op, req_tag, 10'b0};
                        state <= MSG;
                    end
                end
                MSG: begin
                    bus_req <= 1'b0;
                    if (req_op == OP_INV) begin
                        block     <= {req_tag, ST_M, req_wdata};
                        cpu_ready <= 1'b1;
                        cpu_rdata <= req_wdata;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) state <= FILL;
                    else                     lat_cnt <= lat_cnt + 3'd1;
                end
                FILL: begin
                    if (mem_block[15:12] != req_tag) begin
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end else if (req_we) begin
                        block     <= {req_tag, ST_M, req_wdata};
                        cpu_ready <= 1'b1;
                        cpu_rdata <= req_wdata;
                        state     <= DONE;
                    end else begin
                        block     <= {req_tag, ST_S, mem_block[9:0]};
                        cpu_ready <= 1'b1;
                        cpu_rdata <= mem_block[9:0];
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
